// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state encoding and requester ids.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection: on contention the requester not granted last wins.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
    input  req_id_e last_grant,
    output req_id_e grant_id
);

    always_comb begin
        grant_id = REQ_D;
        if (if_req && d_req) begin
            grant_id = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
        end else if (if_req) begin
            grant_id = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port synchronous-read memory, one access per 3 cycles.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    req_id_e       gnt_id_q, gnt_id_d;
    logic [AW-1:0] gnt_addr_q, gnt_addr_d;
    logic          gnt_we_q, gnt_we_d;
    logic [DW-1:0] gnt_wdata_q, gnt_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    req_id_e       pick_id;
    req_id_e       last_grant;
    logic          grant_now;

    assign grant_now = (state_q == IDLE) && (if_req || d_req);

`ifdef MEM_ARBITER_RR_EN
    req_id_e last_grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_IF;
        end else if (grant_now) begin
            last_grant_q <= pick_id;
        end
    end

    assign last_grant = last_grant_q;
`else
    // Pretending fetch was last granted makes the picker favour data on contention.
    assign last_grant = REQ_IF;
`endif

    mem_arbiter_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant_id   (pick_id)
    );

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        gnt_addr_d  = gnt_addr_q;
        gnt_we_d    = gnt_we_q;
        gnt_wdata_d = gnt_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    state_d  = ACCESS;
                    gnt_id_d = pick_id;
                    if (pick_id == REQ_D) begin
                        gnt_addr_d  = d_addr;
                        gnt_we_d    = d_we;
                        gnt_wdata_d = d_wdata;
                    end else begin
                        gnt_addr_d = if_addr;
                        gnt_we_d   = 1'b0;
                    end
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                // Read data is valid in RESP; a write leaves d_rdata untouched.
                if (gnt_id_q == REQ_IF) begin
                    if_rdata_d = mem_rdata;
                end else if (!gnt_we_q) begin
                    d_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_id_q    <= REQ_IF;
            gnt_addr_q  <= '0;
            gnt_we_q    <= 1'b0;
            gnt_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            gnt_addr_q  <= gnt_addr_d;
            gnt_we_q    <= gnt_we_d;
            gnt_wdata_q <= gnt_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Outputs decode from registered state, so reset drops mem_we and acks at once.
    assign mem_addr  = gnt_addr_q;
    assign mem_wdata = gnt_wdata_q;
    assign mem_we    = (state_q == ACCESS) && gnt_we_q;
    assign if_ack    = (state_q == RESP) && (gnt_id_q == REQ_IF);
    assign d_ack     = (state_q == RESP) && (gnt_id_q == REQ_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic        tb_we;
    logic [9:0]  tb_idx;
    logic [31:0] tb_data;

    int checks;
    int errors;
    int both_acks;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_idx] <= tb_data;
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[11:2]];
    end

    always @(negedge clk) begin
        if (if_ack && d_ack) both_acks <= both_acks + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        tb_we   = 1'b1;
        tb_idx  = idx;
        tb_data = data;
        step();
        tb_we   = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_we, if_ack, d_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000", {mem_we, if_ack, d_ack});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata});
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        // if_req has been high throughout reset; the first low edge grants it
        reset = 1'b0;
        step();
        checks++;
        if (dut.state_q !== ACCESS || mem_addr !== 32'h44) begin
            errors++;
            $display("FAIL first_grant: got state %0d addr %h want %0d 44", dut.state_q, mem_addr, ACCESS);
        end
        step();
        checks++;
        if (if_ack !== 1'b1) begin
            errors++;
            $display("FAIL first_ack: got %b want 1", if_ack);
        end
        step();
        if_req = 1'b0;
        checks++;
        if (if_rdata !== 32'h11223344) begin
            errors++;
            $display("FAIL first_rdata: got %h want 11223344", if_rdata);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({if_ack, d_ack, mem_we} !== 3'b000) begin
                errors++;
                $display("FAIL idle_quiet: cycle %0d got %b want 000", i, {if_ack, d_ack, mem_we});
            end
        end
    endtask

    task automatic test_fetch();
        if_req  = 1'b1;
        if_addr = 32'h40;
        step();
        checks++;
        if (mem_addr !== 32'h40 || mem_we !== 1'b0 || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_access: got addr %h we %b ack %b want 40 0 0", mem_addr, mem_we, if_ack);
        end
        step();
        checks++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ack: got if %b d %b want 1 0", if_ack, d_ack);
        end
        step();
        if_req = 1'b0;
        checks++;
        if (if_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ack_len: got %b want 0", if_ack);
        end
        checks++;
        if (if_rdata !== 32'h2402000A) begin
            errors++;
            $display("FAIL fetch_rdata: got %h want 2402000a", if_rdata);
        end
    endtask

    task automatic test_write_read();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEADBEEF;
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_access: got we %b addr %h data %h want 1 100 deadbeef", mem_we, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (mem_we !== 1'b0 || d_ack !== 1'b1 || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_resp: got we %b d_ack %b if_ack %b want 0 1 0", mem_we, d_ack, if_ack);
        end
        step();
        checks++;
        if (mem[64] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_mem: got %h want deadbeef", mem[64]);
        end
        checks++;
        if (d_rdata !== 32'h0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL write_rdata_hold: got rdata %h addr %h want 0 100", d_rdata, mem_addr);
        end
        d_we = 1'b0;
        step();
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_no_we: got %b want 0", mem_we);
        end
        step();
        checks++;
        if (d_ack !== 1'b1) begin
            errors++;
            $display("FAIL read_ack: got %b want 1", d_ack);
        end
        step();
        d_req = 1'b0;
        checks++;
        if (d_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_rdata: got %h want deadbeef", d_rdata);
        end
    endtask

`ifndef MEM_ARBITER_RR_EN
    task automatic test_collision();
        if_req  = 1'b1;
        if_addr = 32'h44;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h80;
        step();
        checks++;
        if (mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL coll_d_first: got addr %h want 80", mem_addr);
        end
        step();
        checks++;
        if (d_ack !== 1'b1 || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL coll_d_ack: got d %b if %b want 1 0", d_ack, if_ack);
        end
        step();
        d_req = 1'b0;
        checks++;
        if (d_rdata !== 32'hA5A50001) begin
            errors++;
            $display("FAIL coll_d_rdata: got %h want a5a50001", d_rdata);
        end
        step();
        checks++;
        if (mem_addr !== 32'h44) begin
            errors++;
            $display("FAIL coll_if_pending: got addr %h want 44", mem_addr);
        end
        step();
        checks++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL coll_if_ack: got if %b d %b want 1 0", if_ack, d_ack);
        end
        step();
        if_req = 1'b0;
        checks++;
        if (if_rdata !== 32'h11223344) begin
            errors++;
            $display("FAIL coll_if_rdata: got %h want 11223344", if_rdata);
        end
        checks++;
        if (both_acks !== 0) begin
            errors++;
            $display("FAIL coll_both_acks: got %0d want 0", both_acks);
        end
    endtask
`else
    task automatic test_rr();
        logic seq [$];
        reset = 1'b1;
        step();
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h40;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        for (int i = 0; i < 12; i++) begin
            step();
            if (d_ack) seq.push_back(1'b1);
            if (if_ack) seq.push_back(1'b0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        checks++;
        if (seq.size() !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d want 4", seq.size());
        end
        for (int i = 0; i < seq.size() && i < 4; i++) begin
            checks++;
            if (seq[i] !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL rr_order: grant %0d got d=%b want d=%b", i, seq[i], (i % 2) == 0);
            end
        end
        checks++;
        if (both_acks !== 0) begin
            errors++;
            $display("FAIL rr_both_acks: got %0d want 0", both_acks);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'hCAFEF00D;
        step();
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_we: got %b want 1", mem_we);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got we %b ack %b want 0 0", mem_we, d_ack);
        end
        d_req = 1'b0;
        step();
        checks++;
        if (mem[128] !== 32'h13572468) begin
            errors++;
            $display("FAIL abort_mem: got %h want 13572468", mem[128]);
        end
        checks++;
        if (dut.state_q !== IDLE || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: got state %0d addr %h data %h want %0d 0 0", dut.state_q, mem_addr, mem_wdata, IDLE);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({d_ack, if_ack, mem_we} !== 3'b000) begin
                errors++;
                $display("FAIL abort_no_ack: cycle %0d got %b want 000", i, {d_ack, if_ack, mem_we});
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        both_acks = 0;
        reset     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h44;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        tb_we     = 1'b0;
        tb_idx    = '0;
        tb_data   = '0;
        preload(10'd16, 32'h2402000A);
        preload(10'd17, 32'h11223344);
        preload(10'd32, 32'hA5A50001);
        preload(10'd64, 32'h00000000);
        preload(10'd128, 32'h13572468);
        test_reset();
        test_idle();
        test_fetch();
        test_write_read();
`ifndef MEM_ARBITER_RR_EN
        test_collision();
`else
        test_rr();
`endif
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
